// File: rtl/fcs_tx_sequencer_if.sv
// Purpose: valid/ready word stream carrying 32-bit payload words with an end-of-frame mark.
// Ports: data (word), valid (word present), last (final word of frame), ready (sink accepts).
// master drives data/valid/last and samples ready; slave is the mirror image.
interface fcs_tx_sequencer_if #(
  parameter int W = 32
);
  logic [W-1:0] data;
  logic         valid;
  logic         last;
  logic         ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/fcs_tx_sequencer.sv
// Purpose: TX frame sequencer; runs CRC-32 over payload, zero-pads short frames, appends ~CRC as FCS.
// Latency: one cycle from accepted input word to out_data; pad and FCS beats follow with no gap.
// Backpressure: single output register advances only when empty or drained; i_in.ready low in PAD/FCS.
// Ports: i_clk, i_rst (sync, active-high), i_pad_en (sampled on the accepted last beat),
//        i_in (slave stream from MAC client), o_out (master stream to MII encoder),
//        o_frame_count (completed frames, wraps at 16 bits).
module fcs_tx_sequencer #(
  parameter int          MIN_WORDS = 15,
  parameter logic [31:0] CRC_POLY  = 32'h04C11DB7
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_pad_en,
  fcs_tx_sequencer_if.slave        i_in,
  fcs_tx_sequencer_if.master       o_out,
  output logic [15:0]              o_frame_count
);

  localparam int                WCNT_W  = $clog2(MIN_WORDS + 1);
  localparam logic [WCNT_W:0]   MIN_EXT = (WCNT_W + 1)'(MIN_WORDS);
  localparam logic [WCNT_W-1:0] MIN_CNT = WCNT_W'(MIN_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAD, S_FCS} state_t;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_crc, w_crc_nxt;
  logic [WCNT_W-1:0] r_wcnt, w_wcnt_nxt;
  logic [31:0]       r_out_data, w_out_data_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              r_out_last, w_out_last_nxt;
  logic [15:0]       r_frame_count, w_frame_count_nxt;

  logic              w_adv;
  logic              w_in_ready;
  logic              w_accept;
  logic [WCNT_W:0]   w_wcnt_inc;

  // MSB-first CRC over one 32-bit word, no reflection.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      r = (r[31] ^ d[i]) ? ((r << 1) ^ CRC_POLY) : (r << 1);
    end
    return r;
  endfunction

  assign w_adv      = !r_out_valid || o_out.ready;
  assign w_in_ready = w_adv && (r_state == S_IDLE || r_state == S_DATA);
  assign w_accept   = i_in.valid && w_in_ready;
  // One extra bit so the compare against MIN_WORDS cannot overflow.
  assign w_wcnt_inc = {1'b0, r_wcnt} + (WCNT_W + 1)'(1);

  always_comb begin
    w_state_nxt       = r_state;
    w_crc_nxt         = r_crc;
    w_wcnt_nxt        = r_wcnt;
    w_out_data_nxt    = r_out_data;
    w_out_valid_nxt   = r_out_valid;
    w_out_last_nxt    = r_out_last;
    w_frame_count_nxt = r_frame_count;

    case (r_state)
      S_IDLE, S_DATA: begin
        if (w_accept) begin
          w_out_data_nxt  = i_in.data;
          w_out_valid_nxt = 1'b1;
          w_out_last_nxt  = 1'b0;
          w_crc_nxt       = crc_upd(r_crc, i_in.data);
          w_wcnt_nxt      = (w_wcnt_inc >= MIN_EXT) ? MIN_CNT : w_wcnt_inc[WCNT_W-1:0];
          if (!i_in.last) begin
            w_state_nxt = S_DATA;
          end else if (i_pad_en && (w_wcnt_inc < MIN_EXT)) begin
            w_state_nxt = S_PAD;
          end else begin
            w_state_nxt = S_FCS;
          end
        end else if (w_adv) begin
          // Input gap: emit a bubble, CRC and count untouched.
          w_out_valid_nxt = 1'b0;
        end
      end
      S_PAD: begin
        if (w_adv) begin
          w_out_data_nxt  = 32'h0;
          w_out_valid_nxt = 1'b1;
          w_out_last_nxt  = 1'b0;
          w_crc_nxt       = crc_upd(r_crc, 32'h0);
          w_wcnt_nxt      = w_wcnt_inc[WCNT_W-1:0];
          if (w_wcnt_inc == MIN_EXT) begin
            w_state_nxt = S_FCS;
          end
        end
      end
      S_FCS: begin
        if (w_adv) begin
          w_out_data_nxt    = ~r_crc;
          w_out_valid_nxt   = 1'b1;
          w_out_last_nxt    = 1'b1;
          w_frame_count_nxt = r_frame_count + 16'd1;
          w_crc_nxt         = 32'hFFFF_FFFF;
          w_wcnt_nxt        = '0;
          w_state_nxt       = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_crc         <= 32'hFFFF_FFFF;
      r_wcnt        <= '0;
      r_out_data    <= 32'h0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_frame_count <= 16'h0;
    end else begin
      r_state       <= w_state_nxt;
      r_crc         <= w_crc_nxt;
      r_wcnt        <= w_wcnt_nxt;
      r_out_data    <= w_out_data_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_last    <= w_out_last_nxt;
      r_frame_count <= w_frame_count_nxt;
    end
  end

  assign i_in.ready    = w_in_ready;
  assign o_out.data    = r_out_data;
  assign o_out.valid   = r_out_valid;
  assign o_out.last    = r_out_last;
  assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_fcs_tx_sequencer.sv
// Purpose: self-checking bench for fcs_tx_sequencer against a table-driven CRC/padding model.
// Latency: n/a (bench); inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: out_ready driven per cycle, randomised in the backpressure scenario.
module tb_fcs_tx_sequencer;

  localparam int          MIN  = 15;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic        clk = 1'b0;
  logic        rst;
  logic        pad_en;
  logic [15:0] frame_count;

  fcs_tx_sequencer_if #(.W(32)) s_if ();
  fcs_tx_sequencer_if #(.W(32)) m_if ();

  fcs_tx_sequencer #(.MIN_WORDS(MIN), .CRC_POLY(POLY)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_pad_en      (pad_en),
    .i_in          (s_if),
    .o_out         (m_if),
    .o_frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] crc_tab [256];
  logic [31:0] in_d [$];
  bit          in_l [$];
  logic [31:0] exp_d [$];
  bit          exp_l [$];
  logic [31:0] got_d [$];
  bit          got_l [$];
  logic [31:0] ref_d [$];
  bit          ref_l [$];
  logic [15:0] exp_fc;
  int          cyc, rdy_low, stall_seen, stall_bad;
  bit          tmo;

  // Byte-at-a-time CRC-32 (non-reflected), bytes taken most significant first.
  function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] r;
    logic [7:0]  b;
    r = c;
    for (int k = 3; k >= 0; k--) begin
      b = r[31:24] ^ w[k*8 +: 8];
      r = (r << 8) ^ crc_tab[b];
    end
    return r;
  endfunction

  // Expected output beats for the whole in_d/in_l stream.
  task automatic model_stream(input bit pad);
    logic [31:0] fr [$];
    logic [31:0] c;
    fr = {};
    exp_d = {};
    exp_l = {};
    for (int i = 0; i < in_d.size(); i++) begin
      fr.push_back(in_d[i]);
      if (in_l[i]) begin
        while (pad && fr.size() < MIN) fr.push_back(32'h0);
        c = 32'hFFFF_FFFF;
        foreach (fr[k]) begin
          c = crc_word(c, fr[k]);
          exp_d.push_back(fr[k]);
          exp_l.push_back(1'b0);
        end
        exp_d.push_back(~c);
        exp_l.push_back(1'b1);
        exp_fc = exp_fc + 16'd1;
        fr = {};
      end
    end
  endtask

  task automatic make_frame(input int n);
    for (int i = 0; i < n; i++) begin
      in_d.push_back($urandom);
      in_l.push_back(i == n - 1);
    end
  endtask

  // Drives in_d/in_l and collects output beats until nframes FCS beats have been taken.
  task automatic run_stream(input bit pad, input int rdy_pct, input int gap_pct, input int nframes);
    int          idx;
    int          done;
    bit          pst;
    logic [31:0] pd;
    bit          pl;
    idx = 0; done = 0; pst = 0; pd = '0; pl = 0;
    got_d = {}; got_l = {};
    cyc = 0; rdy_low = 0; stall_seen = 0; stall_bad = 0; tmo = 0;
    while (done < nframes) begin
      if (cyc >= 3000) begin
        tmo = 1;
        break;
      end
      @(negedge clk);
      cyc++;
      if (pst) begin
        stall_seen++;
        if (m_if.data !== pd || m_if.last !== pl) stall_bad++;
      end
      m_if.ready = ($urandom_range(99) < rdy_pct);
      if (idx < in_d.size()) begin
        s_if.valid = ($urandom_range(99) >= gap_pct);
        s_if.data  = in_d[idx];
        s_if.last  = in_l[idx];
        // pad_en only matters on the last beat, so scramble it elsewhere.
        pad_en     = in_l[idx] ? pad : 1'($urandom_range(1));
      end else begin
        s_if.valid = 1'b0;
        s_if.data  = $urandom;
        s_if.last  = 1'b0;
      end
      #1;
      if (idx == in_d.size() && !s_if.ready) rdy_low++;
      if (s_if.valid && s_if.ready) idx++;
      if (m_if.valid && m_if.ready) begin
        got_d.push_back(m_if.data);
        got_l.push_back(m_if.last);
        if (m_if.last) done++;
      end
      pst = m_if.valid && !m_if.ready;
      pd  = m_if.data;
      pl  = m_if.last;
    end
    s_if.valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; pad_en = 1'b1; m_if.ready = 1'b1;
    s_if.valid = 1'b1; s_if.data = 32'hA5A5_A5A5; s_if.last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (m_if.valid !== 1'b0) begin
        errors++; $display("FAIL reset_valid cyc%0d: got %b want 0", i, m_if.valid);
      end
      checks++;
      if (frame_count !== 16'h0) begin
        errors++; $display("FAIL reset_fc cyc%0d: got %h want 0000", i, frame_count);
      end
    end
    rst = 1'b0; s_if.valid = 1'b0; #1;
    checks++;
    if (s_if.ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", s_if.ready);
    end
    @(negedge clk); #1;
    checks++;
    if (m_if.valid !== 1'b0 || m_if.last !== 1'b0 || m_if.data !== 32'h0) begin
      errors++; $display("FAIL reset_out: got v%b l%b d%h want v0 l0 d00000000",
                         m_if.valid, m_if.last, m_if.data);
    end
    exp_fc = 16'h0;
  endtask

  task automatic test_long_no_pad;
    in_d = {}; in_l = {};
    for (int i = 1; i <= 20; i++) begin
      in_d.push_back(32'(i));
      in_l.push_back(i == 20);
    end
    model_stream(1'b1);
    run_stream(1'b1, 100, 0, 1);
    checks++;
    if (tmo !== 1'b0 || got_d.size() !== 21) begin
      errors++; $display("FAIL long_beats: got %0d (tmo %0d) want 21", got_d.size(), tmo);
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL long_beat%0d: got %h/%0d want %h/%0d",
                           i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (frame_count !== exp_fc) begin
      errors++; $display("FAIL long_fc: got %h want %h", frame_count, exp_fc);
    end
  endtask

  task automatic test_short(input bit pad);
    int nb;
    int lo;
    nb = pad ? 16 : 4;
    lo = pad ? 13 : 1;
    in_d = '{32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF};
    in_l = '{1'b0, 1'b0, 1'b1};
    model_stream(pad);
    run_stream(pad, 100, 0, 1);
    checks++;
    if (tmo !== 1'b0 || got_d.size() !== nb) begin
      errors++; $display("FAIL short%0d_beats: got %0d (tmo %0d) want %0d", pad, got_d.size(), tmo, nb);
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL short%0d_beat%0d: got %h/%0d want %h/%0d",
                           pad, i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (rdy_low !== lo) begin
      errors++; $display("FAIL short%0d_in_ready_low: got %0d want %0d", pad, rdy_low, lo);
    end
    checks++;
    if (frame_count !== exp_fc) begin
      errors++; $display("FAIL short%0d_fc: got %h want %h", pad, frame_count, exp_fc);
    end
  endtask

  task automatic test_backpressure;
    in_d = {}; in_l = {};
    make_frame(17);
    model_stream(1'b1);
    run_stream(1'b1, 100, 0, 1);
    ref_d = got_d;
    ref_l = got_l;
    checks++;
    if (tmo !== 1'b0 || ref_d.size() !== exp_d.size()) begin
      errors++; $display("FAIL bp_ref_beats: got %0d want %0d", ref_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < ref_d.size(); i++) begin
      checks++;
      if (ref_d[i] !== exp_d[i] || ref_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL bp_ref_beat%0d: got %h want %h", i, ref_d[i], exp_d[i]);
      end
    end
    model_stream(1'b1);
    run_stream(1'b1, 50, 30, 1);
    checks++;
    if (tmo !== 1'b0 || got_d.size() !== ref_d.size()) begin
      errors++; $display("FAIL bp_beats: got %0d (tmo %0d) want %0d", got_d.size(), tmo, ref_d.size());
    end
    for (int i = 0; i < ref_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== ref_d[i] || got_l[i] !== ref_l[i]) begin
        errors++; $display("FAIL bp_beat%0d: got %h/%0d want %h/%0d",
                           i, got_d[i], got_l[i], ref_d[i], ref_l[i]);
      end
    end
    checks++;
    if (stall_bad !== 0 || stall_seen == 0) begin
      errors++; $display("FAIL bp_stall_hold: got %0d unstable of %0d stalls want 0 of >0",
                         stall_bad, stall_seen);
    end
    checks++;
    if (frame_count !== exp_fc) begin
      errors++; $display("FAIL bp_fc: got %h want %h", frame_count, exp_fc);
    end
  endtask

  task automatic test_back_to_back;
    bit pad;
    pad = 1'($urandom_range(1));
    in_d = {}; in_l = {};
    for (int f = 0; f < 3; f++) make_frame($urandom_range(20, 1));
    model_stream(pad);
    run_stream(pad, 100, 0, 3);
    checks++;
    if (tmo !== 1'b0 || got_d.size() !== exp_d.size()) begin
      errors++; $display("FAIL b2b_beats: got %0d want %0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL b2b_beat%0d: got %h/%0d want %h/%0d",
                           i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    // One idle cycle to accept the first word, then a beat every cycle.
    checks++;
    if (cyc !== exp_d.size() + 1) begin
      errors++; $display("FAIL b2b_cycles: got %0d want %0d", cyc, exp_d.size() + 1);
    end
    checks++;
    if (frame_count !== exp_fc) begin
      errors++; $display("FAIL b2b_fc: got %h want %h", frame_count, exp_fc);
    end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    s_if.valid = 1'b0;
    force dut.r_frame_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_frame_count;
    #1;
    checks++;
    if (frame_count !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preload: got %h want ffff", frame_count);
    end
    exp_fc = 16'hFFFF;
    in_d = {}; in_l = {};
    make_frame(1);
    model_stream(1'b1);
    run_stream(1'b1, 100, 0, 1);
    checks++;
    if (tmo !== 1'b0 || got_d.size() !== 16) begin
      errors++; $display("FAIL wrap_beats: got %0d want 16", got_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL wrap_beat%0d: got %h want %h", i, got_d[i], exp_d[i]);
      end
    end
    checks++;
    if (frame_count !== 16'h0000) begin
      errors++; $display("FAIL wrap_fc: got %h want 0000", frame_count);
    end
  endtask

  task automatic test_midframe_reset;
    int bad;
    m_if.ready = 1'b1;
    pad_en     = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      s_if.valid = 1'b1; s_if.data = $urandom; s_if.last = 1'b0;
      #1;
      checks++;
      if (s_if.ready !== 1'b1) begin
        errors++; $display("FAIL mid_accept%0d: got in_ready %b want 1", k, s_if.ready);
      end
    end
    @(negedge clk);
    s_if.valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (m_if.valid !== 1'b1 || m_if.last !== 1'b0) begin
      errors++; $display("FAIL mid_word5: got v%b l%b want v1 l0", m_if.valid, m_if.last);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (m_if.valid !== 1'b0 || m_if.data !== 32'h0 || m_if.last !== 1'b0 || s_if.ready !== 1'b1) begin
      errors++; $display("FAIL mid_after_rst: got v%b d%h l%b r%b want v0 d00000000 l0 r1",
                         m_if.valid, m_if.data, m_if.last, s_if.ready);
    end
    checks++;
    if (frame_count !== exp_fc) begin
      errors++; $display("FAIL mid_fc_kept: got %h want %h", frame_count, exp_fc);
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (m_if.valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL mid_no_fcs: got %0d valid beats want 0", bad);
    end
    in_d = {}; in_l = {};
    make_frame(4);
    model_stream(1'b0);
    run_stream(1'b0, 100, 0, 1);
    checks++;
    if (tmo !== 1'b0 || got_d.size() !== 5) begin
      errors++; $display("FAIL mid_next_beats: got %0d want 5", got_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL mid_next_beat%0d: got %h want %h", i, got_d[i], exp_d[i]);
      end
    end
    checks++;
    if (frame_count !== exp_fc) begin
      errors++; $display("FAIL mid_next_fc: got %h want %h", frame_count, exp_fc);
    end
  endtask

  initial begin
    logic [31:0] c;
    rst = 1'b1; pad_en = 1'b0; exp_fc = 16'h0;
    s_if.valid = 1'b0; s_if.data = 32'h0; s_if.last = 1'b0;
    m_if.ready = 1'b1;
    for (int b = 0; b < 256; b++) begin
      c = 32'(b) << 24;
      repeat (8) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
      crc_tab[b] = c;
    end
    test_reset();
    test_long_no_pad();
    test_short(1'b1);
    test_short(1'b0);
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
